// File: rtl/top_level.sv
// top_level: sequential 8-bit ALU on a shared byte bus.
//   Operations (op latched with start): 00 signed add, 01 signed subtract,
//   10 unsigned 8x8 multiply (shift-add), 11 unsigned 16/8 divide (restoring).
//   Operands arrive one byte per cycle after start. The 16-bit result leaves
//   one byte per cycle, and the first byte is marked by finish.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset
//   inbus  in  [7:0] operand byte bus (sampled only in LOAD states)
//   op     in  [1:0] operation select, sampled with start
//   start  in  begin operation (honoured in IDLE and OUT_LO)
//   outbus out [7:0] result byte, 0 when no result is presented
//   finish out strobe on the first result byte (OUT_HI)
//   state  out [3:0] FSM state code
//   A,Q,M  out [7:0] datapath registers (high/remainder, low/quotient, operand/divisor)
module top_level (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inbus,
  input  logic [1:0] op,
  input  logic       start,
  output logic [7:0] outbus,
  output logic       finish,
  output logic [3:0] state,
  output logic [7:0] A,
  output logic [7:0] Q,
  output logic [7:0] M
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD1  = 4'd1,
    S_LOAD2  = 4'd2,
    S_LOAD3  = 4'd3,
    S_ADDSUB = 4'd4,
    S_MUL    = 4'd5,
    S_DIV    = 4'd6,
    S_OUT_HI = 4'd7,
    S_OUT_LO = 4'd8
  } state_t;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] q_q, q_d;
  logic [7:0] m_q, m_d;
  logic [1:0] op_q, op_d;
  logic [2:0] cnt_q, cnt_d;
  logic signed [8:0] r9;

  // 9-bit signed sum/difference of two sign-extended bytes; cannot overflow.
  function automatic logic signed [8:0] addsub9(input logic [7:0] x,
                                                input logic [7:0] y,
                                                input logic       sub);
    logic signed [8:0] xs;
    logic signed [8:0] ys;
    xs = {x[7], x};
    ys = {y[7], y};
    return sub ? (xs - ys) : (xs + ys);
  endfunction

  // One shift-add step: {C,A} = A + (Q[0] ? M : 0), then {C,A,Q} >> 1.
  function automatic logic [15:0] mul_step(input logic [7:0] a,
                                           input logic [7:0] q,
                                           input logic [7:0] m);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, (q[0] ? m : 8'h00)};
    return {sum[8:1], sum[0], q[7:1]};
  endfunction

  // One restoring step. A < M holds throughout, so the shifted partial
  // remainder is below 2*M and the difference always fits back in 8 bits.
  function automatic logic [15:0] div_step(input logic [7:0] a,
                                           input logic [7:0] q,
                                           input logic [7:0] m);
    logic [8:0] pr;
    logic [8:0] diff;
    logic [7:0] qs;
    pr   = {a, q[7]};
    qs   = {q[6:0], 1'b0};
    diff = pr - {1'b0, m};
    if (pr >= {1'b0, m}) begin
      qs[0] = 1'b1;
      return {diff[7:0], qs};
    end
    return {pr[7:0], qs};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      q_q     <= 8'h00;
      m_q     <= 8'h00;
      op_q    <= 2'b00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    r9      = '0;
    outbus  = 8'h00;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          state_d = S_LOAD1;
        end
      end
      S_LOAD1: begin
        if (op_q == OP_DIV) a_d = inbus;
        else                q_d = inbus;
        state_d = S_LOAD2;
      end
      S_LOAD2: begin
        cnt_d = 3'd0;
        if (op_q == OP_DIV) begin
          q_d     = inbus;
          state_d = S_LOAD3;
        end else begin
          m_d     = inbus;
          a_d     = 8'h00;
          state_d = (op_q == OP_MUL) ? S_MUL : S_ADDSUB;
        end
      end
      S_LOAD3: begin
        m_d   = inbus;
        cnt_d = 3'd0;
        // High byte >= divisor means divide-by-zero or a quotient above 255.
        if (a_q >= inbus) begin
          a_d     = 8'hFF;
          q_d     = 8'hFF;
          state_d = S_OUT_HI;
        end else begin
          state_d = S_DIV;
        end
      end
      S_ADDSUB: begin
        r9      = addsub9(q_q, m_q, op_q == OP_SUB);
        q_d     = r9[7:0];
        a_d     = {8{r9[8]}};
        state_d = S_OUT_HI;
      end
      S_MUL: begin
        {a_d, q_d} = mul_step(a_q, q_q, m_q);
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_OUT_HI;
      end
      S_DIV: begin
        {a_d, q_d} = div_step(a_q, q_q, m_q);
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_OUT_HI;
      end
      S_OUT_HI: begin
        finish  = 1'b1;
        outbus  = (op_q == OP_DIV) ? q_q : a_q;
        state_d = S_OUT_LO;
      end
      S_OUT_LO: begin
        outbus = (op_q == OP_DIV) ? a_q : q_q;
        if (start) begin
          op_d    = op;
          state_d = S_LOAD1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;
  assign A     = a_q;
  assign Q     = q_q;
  assign M     = m_q;

endmodule

// File: tb/tb_top_level.sv
// tb_top_level: scoreboard bench for the byte-bus ALU. A driver issues
// operations and pushes the expected two-byte result and finish latency;
// a negedge monitor pops and compares whenever finish is seen.
module tb_top_level;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inbus = 8'h00;
  logic [1:0] op = 2'b00;
  logic       start = 1'b0;
  logic [7:0] outbus, A, Q, M;
  logic       finish;
  logic [3:0] state;

  top_level dut (
    .clk(clk), .rst(rst), .inbus(inbus), .op(op), .start(start),
    .outbus(outbus), .finish(finish), .state(state), .A(A), .Q(Q), .M(M)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    int         lat;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic       pend_lo = 1'b0;
  logic [7:0] exp_lo = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: plain arithmetic on the operand bytes.
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] b0,
                                 input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    int   r;
    int   dvd;
    int   qq;
    int   rr;
    e.lat = 4;
    e.t0  = 0;
    case (o)
      2'b00: r = int'($signed(b0)) + int'($signed(b1));
      2'b01: r = int'($signed(b0)) - int'($signed(b1));
      2'b10: begin
        r     = int'(b0) * int'(b1);
        e.lat = 11;
      end
      default: begin
        dvd = int'(b0) * 256 + int'(b1);
        if (b2 == 8'h00 || (dvd / int'(b2)) > 255) begin
          r = 32'h0000FFFF;
        end else begin
          qq    = dvd / int'(b2);
          rr    = dvd % int'(b2);
          r     = qq * 256 + rr;  // hi byte quotient, lo byte remainder
          e.lat = 12;
        end
      end
    endcase
    e.hi = r[15:8];
    e.lo = r[7:0];
    return e;
  endfunction

  // Monitor: checks result bytes, single-cycle finish, and quiet bus.
  always @(negedge clk) begin
    if (!rst) begin
      if (pend_lo) begin
        chk("lo_byte", outbus, exp_lo);
        chk("lo_finish_low", finish, 0);
        pend_lo = 1'b0;
        done_cnt++;
      end else if (finish) begin
        if (sb.size() == 0) begin
          chk("unexpected_finish", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("hi_byte", outbus, mon_e.hi);
          chk("finish_latency", cyc - mon_e.t0 + 1, mon_e.lat);
          exp_lo  = mon_e.lo;
          pend_lo = 1'b1;
        end
      end else begin
        chk("idle_outbus", outbus, 0);
      end
    end
  end

  // Caller must be away from a rising edge (at a negedge) when calling.
  task automatic issue(input logic [1:0] o, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    start = 1'b1;
    op    = o;
    inbus = 8'($urandom);
    @(posedge clk); #1;
    e    = model(o, b0, b1, b2);
    e.t0 = cyc;
    sb.push_back(e);
    issued++;
    start = 1'b0;
    op    = 2'($urandom);  // must be ignored from here on
    inbus = b0;
    @(posedge clk); #1;
    inbus = b1;
    @(posedge clk); #1;
    if (o == 2'b11) begin
      inbus = b2;
      @(posedge clk); #1;
    end
    inbus = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < issued && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("result_timeout", (done_cnt < issued) ? 1 : 0, 0);
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] o, input logic [7:0] b0,
                     input logic [7:0] b1, input logic [7:0] b2);
    issue(o, b0, b1, b2);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_outbus", outbus, 0);
    chk("rst_finish", finish, 0);
    chk("rst_AQM", {A, Q, M}, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed add / subtract
    run(2'b00, 8'd100, 8'd100, 8'h00);
    run(2'b00, 8'h80, 8'hFF, 8'h00);
    run(2'b01, 8'd5, 8'd10, 8'h00);
    run(2'b01, 8'h80, 8'h7F, 8'h00);

    // Random signed add/sub
    for (int i = 0; i < 8; i++) begin
      run(2'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'h00);
    end

    // Multiply
    run(2'b10, 8'hFF, 8'hFF, 8'h00);
    run(2'b10, 8'h00, 8'h77, 8'h00);
    for (int i = 0; i < 4; i++) begin
      run(2'b10, 8'($urandom), 8'($urandom), 8'h00);
    end

    // Divide, including overflow and divide-by-zero
    run(2'b11, 8'h03, 8'hE8, 8'd10);
    run(2'b11, 8'h00, 8'hFF, 8'd16);
    run(2'b11, 8'h0A, 8'h00, 8'd5);
    run(2'b11, 8'h12, 8'h34, 8'd0);
    for (int i = 0; i < 4; i++) begin
      z = 8'($urandom_range(1, 255));
      x = 8'($urandom_range(0, int'(z) - 1));
      y = 8'($urandom);
      run(2'b11, x, y, z);
    end

    // Back-to-back: start an add during the multiply's OUT_LO cycle
    issue(2'b10, 8'd12, 8'd13, 8'h00);
    n = 0;
    while (!finish && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_finish_seen", finish, 1);
    @(negedge clk);
    issue(2'b00, 8'd20, 8'd22, 8'h00);
    wait_done();

    // Reset in the middle of a multiply
    issue(2'b10, 8'hAB, 8'hCD, 8'h00);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_outbus", outbus, 0);
    chk("midrst_finish", finish, 0);
    chk("midrst_AQM", {A, Q, M}, 0);
    sb.delete();
    pend_lo = 1'b0;
    issued  = done_cnt;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run(2'b00, 8'd3, 8'd4, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
